// File: rtl/calc_pkg.sv
// Shared widths, state encoding and constants for the multiplier-sharing logic.
// Numbers are sign / 34-bit mantissa / signed 7-bit exponent.
package calc_pkg;

   localparam int MANT_W = 34;
   localparam int EXP_W  = 7;

   typedef enum logic [1:0] {
      S_IDLE,
      S_ISSUE,
      S_WAIT,
      S_RESPOND
   } arb_state_t;

   typedef struct packed {
      logic              sign;
      logic [MANT_W-1:0] mant;
      logic [EXP_W-1:0]  exp;
   } num_t;

   localparam num_t ZERO_NUM = '0;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first set request at or above startPtr, wrapping.
// startPtr is kept by the owner as one past the previous winner.
module rr_arbiter #(
   parameter int N_REQ = 2,
   parameter int IDX_W = 2
) (
   input  logic [N_REQ-1:0] req,
   input  logic [IDX_W-1:0] startPtr,
   output logic [N_REQ-1:0] grant,
   output logic             anyReq
);

   always_comb begin
      grant  = '0;
      anyReq = 1'b0;
      for (int k = 0; k < N_REQ; k++) begin
         if (!anyReq && req[(int'(startPtr) + k) % N_REQ]) begin
            grant[(int'(startPtr) + k) % N_REQ] = 1'b1;
            anyReq = 1'b1;
         end
      end
   end

endmodule

// File: rtl/mul_arbiter.sv
// Shares one multiplier between N_REQ requesters: round-robin grant, operand latch,
// eval pulse, wait for done with a watchdog, and a zero-operand shortcut.
module mul_arbiter
   import calc_pkg::*;
#(
   parameter int N_REQ   = 2,
   parameter int TIMEOUT = 64
) (
   input  logic                    clock,
   input  logic                    reset,
   input  logic [N_REQ-1:0]        req,
   input  logic [N_REQ-1:0]        op_sign_a,
   input  logic [N_REQ-1:0]        op_sign_b,
   input  logic [MANT_W*N_REQ-1:0] op_mant_a,
   input  logic [MANT_W*N_REQ-1:0] op_mant_b,
   input  logic [EXP_W*N_REQ-1:0]  op_exp_a,
   input  logic [EXP_W*N_REQ-1:0]  op_exp_b,
   output logic [N_REQ-1:0]        gnt,
   output logic [N_REQ-1:0]        rsp_valid,
   output logic                    rsp_sign,
   output logic [MANT_W-1:0]       rsp_mant,
   output logic [EXP_W-1:0]        rsp_exp,
   output logic                    rsp_err,
   output logic                    busy,
   output logic                    mul_eval,
   output logic                    mul_rst,
   output logic                    mul_sign_a,
   output logic                    mul_sign_b,
   output logic [MANT_W-1:0]       mul_mant_a,
   output logic [MANT_W-1:0]       mul_mant_b,
   output logic [EXP_W-1:0]        mul_exp_a,
   output logic [EXP_W-1:0]        mul_exp_b,
   input  logic                    mul_done,
   input  logic                    mul_sign,
   input  logic [MANT_W-1:0]       mul_mant,
   input  logic [EXP_W-1:0]        mul_exp
);

   localparam int IDX_W = 2;
   localparam int CNT_W = $clog2(TIMEOUT);

   arb_state_t       state;
   logic [IDX_W-1:0] rrPtr;
   logic [IDX_W-1:0] winPtr;
   logic [CNT_W-1:0] wdCount;
   logic [N_REQ-1:0] grant;
   logic             anyReq;
   num_t             selA;
   num_t             selB;
   logic [IDX_W-1:0] selPtr;

   rr_arbiter #(.N_REQ(N_REQ), .IDX_W(IDX_W)) arbiter (
      .req      (req),
      .startPtr (rrPtr),
      .grant    (grant),
      .anyReq   (anyReq)
   );

   // Operand mux for the current pick, plus where the search starts after it.
   always_comb begin
      selA   = ZERO_NUM;
      selB   = ZERO_NUM;
      selPtr = '0;
      for (int i = 0; i < N_REQ; i++) begin
         if (grant[i]) begin
            selA   = {op_sign_a[i], op_mant_a[i*MANT_W +: MANT_W], op_exp_a[i*EXP_W +: EXP_W]};
            selB   = {op_sign_b[i], op_mant_b[i*MANT_W +: MANT_W], op_exp_b[i*EXP_W +: EXP_W]};
            selPtr = IDX_W'((i + 1) % N_REQ);
         end
      end
   end

   // Control FSM; every output is a register, pulses default low each cycle.
   always_ff @(posedge clock) begin
      if (!reset) begin
         state      <= S_IDLE;
         rrPtr      <= '0;
         winPtr     <= '0;
         wdCount    <= '0;
         gnt        <= '0;
         rsp_valid  <= '0;
         rsp_sign   <= 1'b0;
         rsp_mant   <= '0;
         rsp_exp    <= '0;
         rsp_err    <= 1'b0;
         busy       <= 1'b0;
         mul_eval   <= 1'b0;
         mul_rst    <= 1'b0;
         mul_sign_a <= 1'b0;
         mul_sign_b <= 1'b0;
         mul_mant_a <= '0;
         mul_mant_b <= '0;
         mul_exp_a  <= '0;
         mul_exp_b  <= '0;
      end else begin
         mul_eval  <= 1'b0;
         mul_rst   <= 1'b0;
         rsp_valid <= '0;
         case (state)
            S_IDLE: begin
               if (anyReq) begin
                  gnt        <= grant;
                  busy       <= 1'b1;
                  winPtr     <= selPtr;
                  mul_sign_a <= selA.sign;
                  mul_sign_b <= selB.sign;
                  mul_mant_a <= selA.mant;
                  mul_mant_b <= selB.mant;
                  mul_exp_a  <= selA.exp;
                  mul_exp_b  <= selB.exp;
                  // A zero mantissa gives a zero result without touching the multiplier.
                  if (selA.mant == '0 || selB.mant == '0) begin
                     {rsp_sign, rsp_mant, rsp_exp} <= ZERO_NUM;
                     rsp_err <= 1'b0;
                     state   <= S_RESPOND;
                  end else begin
                     mul_eval <= 1'b1;
                     state    <= S_ISSUE;
                  end
               end
            end
            S_ISSUE: begin
               wdCount <= '0;
               state   <= S_WAIT;
            end
            S_WAIT: begin
               if (mul_done) begin
                  rsp_sign <= mul_sign;
                  rsp_mant <= mul_mant;
                  rsp_exp  <= mul_exp;
                  rsp_err  <= 1'b0;
                  state    <= S_RESPOND;
               end else if (wdCount == CNT_W'(TIMEOUT - 1)) begin
                  {rsp_sign, rsp_mant, rsp_exp} <= ZERO_NUM;
                  rsp_err <= 1'b1;
                  mul_rst <= 1'b1;
                  state   <= S_RESPOND;
               end else begin
                  wdCount <= wdCount + 1'b1;
               end
            end
            S_RESPOND: begin
               rsp_valid <= gnt;
               gnt       <= '0;
               busy      <= 1'b0;
               rrPtr     <= winPtr;
               state     <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mul_arbiter.sv
// Scoreboard bench for mul_arbiter with a stub multiplier of programmable latency.
// Stimulus pushes expected responses; a monitor pops them whenever rsp_valid is seen.
module tb_mul_arbiter;

   localparam int N  = 2;
   localparam int TO = 16;

   logic          clock = 1'b0;
   logic          reset;
   logic [N-1:0]  req;
   logic [N-1:0]  op_sign_a, op_sign_b;
   logic [34*N-1:0] op_mant_a, op_mant_b;
   logic [7*N-1:0]  op_exp_a, op_exp_b;
   logic [N-1:0]  gnt, rsp_valid;
   logic          rsp_sign, rsp_err, busy, mul_eval, mul_rst;
   logic [33:0]   rsp_mant;
   logic [6:0]    rsp_exp;
   logic          mul_sign_a, mul_sign_b;
   logic [33:0]   mul_mant_a, mul_mant_b;
   logic [6:0]    mul_exp_a, mul_exp_b;
   logic          mul_done, mul_sign;
   logic [33:0]   mul_mant;
   logic [6:0]    mul_exp;

   mul_arbiter #(.N_REQ(N), .TIMEOUT(TO)) dut (
      .clock(clock), .reset(reset), .req(req),
      .op_sign_a(op_sign_a), .op_sign_b(op_sign_b),
      .op_mant_a(op_mant_a), .op_mant_b(op_mant_b),
      .op_exp_a(op_exp_a), .op_exp_b(op_exp_b),
      .gnt(gnt), .rsp_valid(rsp_valid), .rsp_sign(rsp_sign), .rsp_mant(rsp_mant),
      .rsp_exp(rsp_exp), .rsp_err(rsp_err), .busy(busy),
      .mul_eval(mul_eval), .mul_rst(mul_rst),
      .mul_sign_a(mul_sign_a), .mul_sign_b(mul_sign_b),
      .mul_mant_a(mul_mant_a), .mul_mant_b(mul_mant_b),
      .mul_exp_a(mul_exp_a), .mul_exp_b(mul_exp_b),
      .mul_done(mul_done), .mul_sign(mul_sign), .mul_mant(mul_mant), .mul_exp(mul_exp)
   );

   always #5 clock = ~clock;

   typedef struct {
      logic [N-1:0] valid;
      logic         sign;
      logic [33:0]  mant;
      logic [6:0]   exp;
      logic         err;
   } exp_t;

   exp_t expQ[$];
   int   compared   = 0;
   int   mismatched = 0;
   int   cyc        = 0;
   int   evalCount  = 0;
   int   rstCount   = 0;
   int   lastEvalCycle = 0;
   int   lastRstCycle  = 0;
   int   stubLat    = 3;

   task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
      compared++;
      if (actual !== expected) begin
         mismatched++;
         $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
      end
   endtask

   task automatic pushExpect(input logic [N-1:0] v, input logic s, input logic [33:0] m,
                             input logic [6:0] e, input logic err);
      exp_t x;
      x.valid = v; x.sign = s; x.mant = m; x.exp = e; x.err = err;
      expQ.push_back(x);
   endtask

   task automatic applyStimulus(input int idx, input logic sa, input logic [33:0] ma, input logic [6:0] ea,
                                input logic sb, input logic [33:0] mb, input logic [6:0] eb);
      op_sign_a[idx] = sa;
      op_sign_b[idx] = sb;
      op_mant_a[idx*34 +: 34] = ma;
      op_mant_b[idx*34 +: 34] = mb;
      op_exp_a[idx*7 +: 7] = ea;
      op_exp_b[idx*7 +: 7] = eb;
      req[idx] = 1'b1;
   endtask

   task automatic waitResponse(input int idx, output int cycles);
      bit seen = 0;
      cycles = 0;
      for (int n = 0; n < 200 && !seen; n++) begin
         @(negedge clock);
         cycles++;
         if (rsp_valid[idx]) begin
            req[idx] = 1'b0;
            seen = 1;
         end
      end
      if (!seen) checkOutput("response_timeout", 64'd0, 64'd1);
   endtask

   initial forever begin
      @(posedge clock);
      cyc++;
   end

   // Stub multiplier: answers stubLat cycles after eval; negative latency hangs.
   initial begin
      logic [67:0] prod;
      mul_done = 1'b0; mul_sign = 1'b0; mul_mant = '0; mul_exp = '0;
      forever begin
         @(negedge clock);
         if (mul_eval && stubLat >= 0) begin
            prod = 68'(mul_mant_a) * 68'(mul_mant_b);
            repeat (stubLat) @(negedge clock);
            mul_sign = mul_sign_a ^ mul_sign_b;
            mul_mant = prod[33:0];
            mul_exp  = mul_exp_a + mul_exp_b;
            mul_done = 1'b1;
            @(negedge clock);
            mul_done = 1'b0;
         end
      end
   end

   // Monitor: eval spacing, pulse bookkeeping, and scoreboard compare on rsp_valid.
   initial begin
      logic prevEval = 1'b0;
      exp_t e;
      forever begin
         @(negedge clock);
         if (mul_eval) begin
            evalCount++;
            lastEvalCycle = cyc;
            checkOutput("eval_back_to_back", 64'(prevEval), 64'd0);
         end
         prevEval = mul_eval;
         if (mul_rst) begin
            rstCount++;
            lastRstCycle = cyc;
         end
         if (rsp_valid != '0) begin
            if (expQ.size() == 0) begin
               compared++;
               mismatched++;
               $display("[TB] FAIL unexpected_rsp: got rsp_valid %b, expected none", rsp_valid);
            end else begin
               e = expQ.pop_front();
               checkOutput("rsp_valid", 64'(rsp_valid), 64'(e.valid));
               checkOutput("rsp_sign", 64'(rsp_sign), 64'(e.sign));
               checkOutput("rsp_mant", 64'(rsp_mant), 64'(e.mant));
               checkOutput("rsp_exp", 64'(rsp_exp), 64'(e.exp));
               checkOutput("rsp_err", 64'(rsp_err), 64'(e.err));
               checkOutput("gnt_cleared", 64'(gnt), 64'd0);
            end
         end
      end
   end

   initial begin
      #200000;
      $display("[TB] FAIL global_timeout: simulation did not finish");
      $fatal(1, "[TB] time limit");
   end

   initial begin
      int lat, ev0, rs0, got;
      reset = 1'b0; req = '0;
      op_sign_a = '0; op_sign_b = '0; op_mant_a = '0; op_mant_b = '0; op_exp_a = '0; op_exp_b = '0;
      repeat (3) @(negedge clock);
      checkOutput("reset_gnt", 64'(gnt), 64'd0);
      checkOutput("reset_busy", 64'(busy), 64'd0);
      checkOutput("reset_eval", 64'(mul_eval), 64'd0);
      checkOutput("reset_rsp_valid", 64'(rsp_valid), 64'd0);
      reset = 1'b1;
      @(negedge clock);

      $display("[TB] single request on port 0");
      ev0 = evalCount;
      applyStimulus(0, 1'b0, 34'd25, 7'd0, 1'b1, 34'd4, 7'd1);
      pushExpect(2'b01, 1'b1, 34'd100, 7'd1, 1'b0);
      @(negedge clock);
      checkOutput("t1_gnt", 64'(gnt), 64'h1);
      checkOutput("t1_busy", 64'(busy), 64'd1);
      waitResponse(0, lat);
      checkOutput("t1_eval_count", 64'(evalCount - ev0), 64'd1);
      @(negedge clock);

      $display("[TB] zero mantissa shortcut on port 1");
      ev0 = evalCount;
      applyStimulus(1, 1'b0, 34'd0, 7'd0, 1'b0, 34'd7, 7'd3);
      pushExpect(2'b10, 1'b0, 34'd0, 7'd0, 1'b0);
      waitResponse(1, lat);
      checkOutput("t3_latency", 64'(lat), 64'd2);
      checkOutput("t3_no_eval", 64'(evalCount - ev0), 64'd0);
      @(negedge clock);

      $display("[TB] both ports held for four operations");
      ev0 = evalCount;
      applyStimulus(0, 1'b0, 34'd3, 7'd2, 1'b0, 34'd5, 7'd1);
      applyStimulus(1, 1'b1, 34'd6, 7'h7F, 1'b1, 34'd7, 7'h7E);
      for (int k = 0; k < 2; k++) begin
         pushExpect(2'b01, 1'b0, 34'd15, 7'd3, 1'b0);
         pushExpect(2'b10, 1'b0, 34'd42, 7'h7D, 1'b0);
      end
      got = 0;
      for (int n = 0; n < 400 && got < 4; n++) begin
         @(negedge clock);
         if (rsp_valid != '0) begin
            got++;
            if (got == 4) req = '0;
         end
      end
      checkOutput("t2_responses", 64'(got), 64'd4);
      checkOutput("t2_eval_count", 64'(evalCount - ev0), 64'd4);
      @(negedge clock);

      $display("[TB] watchdog with a hung multiplier");
      stubLat = -1;
      rs0 = rstCount;
      applyStimulus(0, 1'b0, 34'd5, 7'd0, 1'b0, 34'd5, 7'd0);
      pushExpect(2'b01, 1'b0, 34'd0, 7'd0, 1'b1);
      waitResponse(0, lat);
      checkOutput("t4_rst_count", 64'(rstCount - rs0), 64'd1);
      checkOutput("t4_rst_delay", 64'(lastRstCycle - lastEvalCycle), 64'(TO + 1));
      stubLat = 3;
      applyStimulus(1, 1'b0, 34'd9, 7'd2, 1'b0, 34'd11, 7'h7F);
      pushExpect(2'b10, 1'b0, 34'd99, 7'd1, 1'b0);
      waitResponse(1, lat);
      @(negedge clock);

      $display("[TB] reset in the middle of WAIT");
      stubLat = 6;
      applyStimulus(0, 1'b0, 34'd8, 7'd1, 1'b0, 34'd8, 7'd1);
      got = 0;
      for (int n = 0; n < 20 && got == 0; n++) begin
         @(negedge clock);
         if (mul_eval) got = 1;
      end
      checkOutput("t5_eval_seen", 64'(got), 64'd1);
      repeat (2) @(negedge clock);
      reset = 1'b0;
      req = '0;
      @(negedge clock);
      checkOutput("t5_gnt", 64'(gnt), 64'd0);
      checkOutput("t5_busy", 64'(busy), 64'd0);
      checkOutput("t5_mul_mant_a", 64'(mul_mant_a), 64'd0);
      checkOutput("t5_rsp_mant", 64'(rsp_mant), 64'd0);
      checkOutput("t5_mul_rst", 64'(mul_rst), 64'd0);
      reset = 1'b1;
      repeat (12) @(negedge clock);
      checkOutput("t5_idle_after_late_done", 64'(busy), 64'd0);
      ev0 = evalCount;
      stubLat = 3;
      applyStimulus(1, 1'b0, 34'd2, 7'd0, 1'b0, 34'd3, 7'd0);
      pushExpect(2'b10, 1'b0, 34'd6, 7'd0, 1'b0);
      waitResponse(1, lat);
      checkOutput("t5_fresh_eval", 64'(evalCount - ev0), 64'd1);
      @(negedge clock);

      $display("[TB] done coincides with the watchdog limit");
      stubLat = TO;
      rs0 = rstCount;
      applyStimulus(0, 1'b1, 34'd12, 7'd5, 1'b0, 34'd10, 7'h79);
      pushExpect(2'b01, 1'b1, 34'd120, 7'h7E, 1'b0);
      waitResponse(0, lat);
      checkOutput("t6_no_rst", 64'(rstCount - rs0), 64'd0);
      repeat (3) @(negedge clock);

      checkOutput("scoreboard_drained", 64'(expQ.size()), 64'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
